digit_serial_mul: RTL and testbench

DIGIT_SERIAL_MUL -- requirements
Module: digit_serial_mul

---
 rtl/digit_serial_mul.sv | 138 +++++++++++++
 tb/tb_digit_serial_mul.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_mul.sv
// Digit-serial signed/unsigned multiplier: one DIGITxDIGIT partial product per cycle,
// K*K cycles per operation, followed by a sign-fixup cycle and a valid/ready result hold.
module digit_serial_mul #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mul_in_1,
  input  logic [WIDTH-1:0]     mul_in_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mul_out,
  output logic                 busy
);

  localparam int K  = WIDTH / DIGIT;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, COMPUTE, SIGN, DONE} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 neg_q;
  logic [PW-1:0]        acc_q;
  logic [IW-1:0]        i_q, j_q;
  logic [PW-1:0]        mul_out_q;
  logic                 in_ready_q, busy_q, out_valid_q;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [DIGIT-1:0]     digit_a, digit_b;
  logic [2*DIGIT-1:0]   prod;
  logic [PW-1:0]        acc_d, result_d;
  logic                 last_j, last_i;

  // Magnitudes fit in WIDTH unsigned bits, so -2^(WIDTH-1) needs no extra headroom.
  always_comb begin
    // NOTE: every always_comb output is given a value on every path so no latch is inferred.
    abs_a    = (signed_mode && mul_in_1[WIDTH-1]) ? ({WIDTH{1'b0}} - mul_in_1) : mul_in_1;
    abs_b    = (signed_mode && mul_in_2[WIDTH-1]) ? ({WIDTH{1'b0}} - mul_in_2) : mul_in_2;
    digit_a  = a_q[int'(i_q)*DIGIT +: DIGIT];
    digit_b  = b_q[int'(j_q)*DIGIT +: DIGIT];
    prod     = digit_a * digit_b;
    acc_d    = acc_q + (PW'(prod) << (DIGIT * (int'(i_q) + int'(j_q))));
    result_d = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
    last_j   = (j_q == IW'(K - 1));
    last_i   = (i_q == IW'(K - 1));
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      mul_out_q   <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      // Abort wins over accept and over the output handshake.
      state_q     <= IDLE;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      mul_out_q   <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= abs_a;
            b_q        <= abs_b;
            neg_q      <= signed_mode & (mul_in_1[WIDTH-1] ^ mul_in_2[WIDTH-1]);
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            state_q    <= COMPUTE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        COMPUTE: begin
          acc_q <= acc_d;
          if (last_j) begin
            j_q <= '0;
            if (last_i) begin
              i_q     <= '0;
              state_q <= SIGN;
            end else begin
              i_q <= i_q + IW'(1);
            end
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        SIGN: begin
          mul_out_q   <= result_d;
          state_q     <= DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          // Going to IDLE here (not straight to COMPUTE) keeps results from overlapping.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign mul_out   = mul_out_q;

endmodule

// File: tb/tb_digit_serial_mul.sv
// Self-checking bench for digit_serial_mul: scoreboard of expected products,
// latency, backpressure, back-to-back, abort and mid-operation reset scenarios.
module tb_digit_serial_mul;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int K     = WIDTH / DIGIT;
  localparam int LAT   = K * K + 2;
  localparam int PW    = 2 * WIDTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic              signed_mode;
  logic [WIDTH-1:0]  mul_in_1, mul_in_2;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     mul_out;
  logic              busy;

  int checks = 0;
  int passed = 0;
  logic [PW-1:0] exp_q [$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic [PW-1:0]    p;
  } vec_t;

  vec_t vecs [9] = '{
    '{16'h1234, 16'h5678, 1'b0, 32'h06260060},
    '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
    '{16'h0000, 16'hFFFF, 1'b0, 32'h00000000},
    '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001},
    '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
    '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000},
    '{16'h0000, 16'h8000, 1'b1, 32'h00000000},
    '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA},
    '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000}
  };

  digit_serial_mul #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .mul_in_1   (mul_in_1),
    .mul_in_2   (mul_in_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mul_out    (mul_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic sm);
    logic signed [PW-1:0] sa, sb;
    if (sm) begin
      sa = {{WIDTH{a[WIDTH-1]}}, a};
      sb = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      sa = {{WIDTH{1'b0}}, a};
      sb = {{WIDTH{1'b0}}, b};
    end
    return sa * sb;
  endfunction

  // Drives one accept while IDLE and leaves the time 1 unit after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sm, input logic [PW-1:0] p);
    mul_in_1    = a;
    mul_in_2    = b;
    signed_mode = sm;
    in_valid    = 1'b1;
    exp_q.push_back(p);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges with the accept edge as 1 until out_valid is seen, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < LAT + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  function automatic logic [PW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; signed_mode = 1'b0;
    mul_in_1 = '0; mul_in_2 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (mul_out !== '0) $display("FAIL reset_mul_out got %h want 0", mul_out); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int cyc;
    logic [PW-1:0] e;
    foreach (vecs[n]) begin
      start_op(vecs[n].a, vecs[n].b, vecs[n].sm, vecs[n].p);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL dir%0d_busy got busy=%b in_ready=%b want 1/0", n, busy, in_ready);
      else passed++;
      wait_valid(cyc);
      checks++; if (cyc != LAT) $display("FAIL dir%0d_latency got %0d want %0d", n, cyc, LAT); else passed++;
      e = pop_exp();
      checks++; if (mul_out !== e) $display("FAIL dir%0d_product got %h want %h", n, mul_out, e); else passed++;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL dir%0d_idle got in_ready=%b out_valid=%b want 1/0", n, in_ready, out_valid);
      else passed++;
      checks++; if (mul_out !== e) $display("FAIL dir%0d_retain got %h want %h", n, mul_out, e); else passed++;
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [WIDTH-1:0] a, b;
    logic sm;
    logic [PW-1:0] e;
    for (int n = 0; n < 8; n++) begin
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      sm = 1'($urandom_range(0, 1));
      start_op(a, b, sm, model(a, b, sm));
      wait_valid(cyc);
      checks++; if (cyc != LAT) $display("FAIL rnd%0d_latency got %0d want %0d", n, cyc, LAT); else passed++;
      e = pop_exp();
      checks++;
      if (mul_out !== e) $display("FAIL rnd%0d_product a=%h b=%h sm=%b got %h want %h", n, a, b, sm, mul_out, e);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [PW-1:0] e;
    start_op(16'h00FF, 16'h0F0F, 1'b0, model(16'h00FF, 16'h0F0F, 1'b0));
    mul_in_1 = 16'hC001; mul_in_2 = 16'h7FFF; signed_mode = 1'b1; in_valid = 1'b1;
    exp_q.push_back(model(16'hC001, 16'h7FFF, 1'b1));
    wait_valid(cyc);
    checks++; if (cyc != LAT) $display("FAIL b2b_first_latency got %0d want %0d", cyc, LAT); else passed++;
    e = pop_exp();
    checks++; if (mul_out !== e) $display("FAIL b2b_first_product got %h want %h", mul_out, e); else passed++;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL b2b_no_overlap got in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got busy=%b want 1", busy); else passed++;
    wait_valid(cyc);
    checks++; if (cyc != LAT) $display("FAIL b2b_second_latency got %0d want %0d", cyc, LAT); else passed++;
    e = pop_exp();
    checks++; if (mul_out !== e) $display("FAIL b2b_second_product got %h want %h", mul_out, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [PW-1:0] e;
    out_ready = 1'b0;
    start_op(16'hABCD, 16'h1357, 1'b0, model(16'hABCD, 16'h1357, 1'b0));
    mul_in_1 = 16'hFFFF; mul_in_2 = 16'hFFFF; signed_mode = 1'b1; in_valid = 1'b1;
    wait_valid(cyc);
    checks++; if (cyc != LAT) $display("FAIL bp_latency got %0d want %0d", cyc, LAT); else passed++;
    e = pop_exp();
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (mul_out !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got mul_out=%h out_valid=%b in_ready=%b want %h/1/0",
                 n, mul_out, out_valid, in_ready, e);
      else passed++;
      in_valid = ~in_valid;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    else passed++;
    checks++; if (mul_out !== e) $display("FAIL bp_retain got %h want %h", mul_out, e); else passed++;
  endtask

  task automatic test_reset_mid_op;
    int cyc;
    int seen;
    logic [PW-1:0] e;
    start_op(16'h4321, 16'h8765, 1'b0, '0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mul_out !== '0)
      $display("FAIL rst_mid_outputs got in_ready=%b busy=%b out_valid=%b mul_out=%h want 1/0/0/0",
               in_ready, busy, out_valid, mul_out);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) $display("FAIL rst_mid_spurious got %0d valid cycles want 0", seen); else passed++;
    start_op(16'h8001, 16'h7FFF, 1'b1, model(16'h8001, 16'h7FFF, 1'b1));
    wait_valid(cyc);
    checks++; if (cyc != LAT) $display("FAIL rst_mid_fresh_latency got %0d want %0d", cyc, LAT); else passed++;
    e = pop_exp();
    checks++; if (mul_out !== e) $display("FAIL rst_mid_fresh_product got %h want %h", mul_out, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    int seen;
    start_op(16'h2222, 16'h3333, 1'b0, '0);
    void'(exp_q.pop_back());
    repeat (6) @(posedge clk);
    #1;
    clear = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mul_out !== '0)
      $display("FAIL clear_abort got in_ready=%b busy=%b out_valid=%b mul_out=%h want 1/0/0/0",
               in_ready, busy, out_valid, mul_out);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL clear_over_accept got in_ready=%b busy=%b want 1/0", in_ready, busy);
    else passed++;
    clear = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) $display("FAIL clear_spurious got %0d valid cycles want 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_clear();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
